// File: rtl/pac_multi_pkg.sv
// Shared constants and types for the multi-voice phase accumulator and its
// downstream sine stage.
package pac_multi_pkg;

  localparam int CLK_FREQ     = 48_000_000;
  localparam int PAC_FREQ     = 48_000;
  localparam int PAC_TICK_DIV = CLK_FREQ / PAC_FREQ;
  localparam int SINE_WORDS   = 4096;
  localparam int PAC_OUT_W    = $clog2(SINE_WORDS);
  localparam int PAC_VOICES   = 8;
  localparam int PAC_VA_W     = $clog2(PAC_VOICES);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } pac_state_e;

  // Phase word handed to the sine-approximation stage at default sizing.
  typedef struct packed {
    logic [PAC_VA_W-1:0]  voice;
    logic [PAC_OUT_W-1:0] phase;
    logic                 wrap;
    logic                 valid;
  } pac2sine_t;

  function automatic int va_width(input int voices);
    return (voices > 1) ? $clog2(voices) : 1;
  endfunction

endpackage

// File: rtl/pac_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clk cycles, first tick DIV
// cycles after reset release.
module pac_tick_gen #(
  parameter int DIV   = 1000,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pac_multi.sv
// Time-multiplexed NUM_VOICES phase accumulator with per-voice clear and wrap
// reporting. Define PAC_SYNC_EN to enable per-voice hard sync to the previous voice.
module pac_multi
  import pac_multi_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = PAC_OUT_W,
  parameter int TICK_DIV   = PAC_TICK_DIV,
  parameter int VA_W       = va_width(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_we,
  input  logic [VA_W-1:0]       inc_addr,
  input  logic [PHASE_W-1:0]    inc_data,
  input  logic                  clr_we,
  input  logic [VA_W-1:0]       clr_addr,
  input  logic [NUM_VOICES-1:0] sync_mask,
  output logic                  tick,
  output logic                  out_valid,
  output logic [VA_W-1:0]       out_voice,
  output logic [OUT_W-1:0]      out_phase,
  output logic                  out_wrap,
  output logic                  busy
);

  if (TICK_DIV < NUM_VOICES + 2) begin : g_bad_tick_div
    $error("pac_multi: TICK_DIV must be >= NUM_VOICES+2");
  end
  if (OUT_W > PHASE_W) begin : g_bad_out_w
    $error("pac_multi: OUT_W must not exceed PHASE_W");
  end

  pac_state_e state_q, state_d;
  logic [VA_W-1:0]    v_q, v_d;
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
  logic               out_valid_q, out_wrap_q;
  logic [VA_W-1:0]    out_voice_q;
  logic [OUT_W-1:0]   out_phase_q;
  logic               upd;
  logic               load_zero;
  logic [PHASE_W:0]   sum;

  function automatic logic [PHASE_W:0] wrap_add(input logic [PHASE_W-1:0] a,
                                                input logic [PHASE_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  pac_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SWEEP;
          v_d     = '0;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        v_d  = v_q + VA_W'(1);
        if (v_q == VA_W'(NUM_VOICES - 1)) begin
          state_d = IDLE;
          v_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
    end
  end

  assign upd = (state_q == SWEEP);

  // A clear (or sync) on the voice being updated overrides the add result.
  always_comb begin
    sum       = wrap_add(phase_q[v_q], inc_q[v_q]);
    load_zero = clr_we && (clr_addr == v_q);
`ifdef PAC_SYNC_EN
    // out_wrap_q still holds the previous voice's carry from this sweep.
    if ((v_q != '0) && sync_mask[v_q] && out_wrap_q) load_zero = 1'b1;
`endif
  end

`ifndef PAC_SYNC_EN
  logic sync_unused;
  assign sync_unused = ^sync_mask;
`endif

  // Only addresses matching a real voice hit the loop, so out-of-range writes drop out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (inc_we && (inc_addr == VA_W'(i))) inc_q[i] <= inc_data;
        if (clr_we && (clr_addr == VA_W'(i))) begin
          phase_q[i] <= '0;
        end else if (upd && (v_q == VA_W'(i))) begin
          phase_q[i] <= load_zero ? '0 : sum[PHASE_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_voice_q <= '0;
      out_phase_q <= '0;
      out_wrap_q  <= 1'b0;
    end else begin
      out_valid_q <= upd;
      out_wrap_q  <= upd && !load_zero && sum[PHASE_W];
      if (upd) begin
        out_voice_q <= v_q;
        out_phase_q <= load_zero ? '0 : sum[PHASE_W-1 -: OUT_W];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_voice = out_voice_q;
  assign out_phase = out_phase_q;
  assign out_wrap  = out_wrap_q;

endmodule

// File: tb/tb_pac_multi.sv
// Bench for pac_multi: slot-arithmetic reference model plus directed and random
// stimulus; 5 voices so that addresses 5..7 are out of range.
module tb_pac_multi;

  localparam int NV   = 5;
  localparam int P_W  = 8;
  localparam int O_W  = 8;
  localparam int TD   = 10;
  localparam int VA_W = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            inc_we = 1'b0;
  logic [VA_W-1:0] inc_addr = '0;
  logic [P_W-1:0]  inc_data = '0;
  logic            clr_we = 1'b0;
  logic [VA_W-1:0] clr_addr = '0;
  logic [NV-1:0]   sync_mask = '0;
  logic            tick, out_valid, out_wrap, busy;
  logic [VA_W-1:0] out_voice;
  logic [O_W-1:0]  out_phase;

  pac_multi #(.NUM_VOICES(NV), .PHASE_W(P_W), .OUT_W(O_W), .TICK_DIV(TD), .VA_W(VA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_we    (inc_we),
    .inc_addr  (inc_addr),
    .inc_data  (inc_data),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .sync_mask (sync_mask),
    .tick      (tick),
    .out_valid (out_valid),
    .out_voice (out_voice),
    .out_phase (out_phase),
    .out_wrap  (out_wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edges counted since reset release. Edge k updates voice
  // (k mod TD)-1 when that lies in 0..NV-1 and k >= TD.
  int cyc = 0;
  int m_phase [NV];
  int m_inc   [NV];
  int e_tick = 0, e_busy = 0, e_valid = 0, e_voice = 0, e_phase = 0, e_wrap = 0;
  int prev_wrap = 0;

  task automatic model_step();
    int slot, v, s, zero;
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < NV; i++) begin
        m_phase[i] = 0;
        m_inc[i]   = 0;
      end
      e_valid = 0; e_voice = 0; e_phase = 0; e_wrap = 0; prev_wrap = 0;
    end else begin
      cyc++;
      slot    = cyc % TD;
      e_valid = 0;
      e_wrap  = 0;
      if (cyc >= TD && slot >= 1 && slot <= NV) begin
        v    = slot - 1;
        s    = m_phase[v] + m_inc[v];
        zero = (clr_we && int'(clr_addr) == v) ? 1 : 0;
`ifdef PAC_SYNC_EN
        if (v > 0 && sync_mask[v] && prev_wrap != 0) zero = 1;
`endif
        if (zero != 0) begin
          m_phase[v] = 0;
        end else begin
          m_phase[v] = s % (1 << P_W);
          e_wrap     = (s >= (1 << P_W)) ? 1 : 0;
        end
        prev_wrap = e_wrap;
        e_valid   = 1;
        e_voice   = v;
        e_phase   = m_phase[v] >> (P_W - O_W);
      end
      if (inc_we && int'(inc_addr) < NV) m_inc[inc_addr] = int'(inc_data);
      if (clr_we && int'(clr_addr) < NV) m_phase[clr_addr] = 0;
    end
    e_tick = (cyc % TD == TD - 1) ? 1 : 0;
    e_busy = (cyc >= TD && (cyc % TD) < NV) ? 1 : 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("tick",  32'(tick),      e_tick);
    chk("busy",  32'(busy),      e_busy);
    chk("valid", 32'(out_valid), e_valid);
    chk("voice", 32'(out_voice), e_voice);
    chk("phase", 32'(out_phase), e_phase);
    chk("wrap",  32'(out_wrap),  e_wrap);
  end

  // Called just after a negedge; leaves reset released before the next posedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tick",  32'(tick),      0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_wrap",  32'(out_wrap),  0);
    chk("rst_voice", 32'(out_voice), 0);
    chk("rst_phase", 32'(out_phase), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic write_inc(input int v, input int d);
    @(negedge clk);
    inc_we   = 1'b1;
    inc_addr = VA_W'(v);
    inc_data = P_W'(d);
    @(negedge clk);
    inc_we   = 1'b0;
  endtask

  task automatic wait_mod(input int m);
    for (int i = 0; i < 2 * TD; i++) begin
      @(negedge clk);
      if (cyc >= TD && (cyc % TD) == m) break;
    end
  endtask

  task automatic wait_slot(input int v, output int ph, output int wr);
    int found;
    found = 0;
    ph = 0;
    wr = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if (out_valid && int'(out_voice) == v) begin
        found = 1;
        break;
      end
    end
    if (found == 0) chk("slot_timeout", 0, 1);
    else begin
      ph = int'(out_phase);
      wr = int'(out_wrap);
    end
  endtask

  int ph, wr, c, tcyc;
  int seq_a   [4] = '{32'h40, 32'h80, 32'hC0, 32'h00};
`ifdef PAC_SYNC_EN
  int seq_s   [3] = '{32'h30, 32'h00, 32'h30};
`else
  int seq_s   [3] = '{32'h30, 32'h60, 32'h90};
`endif

  initial begin
    // Reset and first-tick timing; cycle 1 is the one in which reset is released.
    @(negedge clk);
    do_reset();
    c = 1;
    tcyc = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      c++;
      if (tick && tcyc == 0) tcyc = c;
      if (out_valid) break;
    end
    chk("first_tick_cycle", tcyc, TD);
    chk("valid_latency", c - tcyc, 2);

    // Wrap sequence on voice 1.
    wait_mod(NV + 1);
    write_inc(1, 32'h40);
    for (int k = 0; k < 4; k++) begin
      wait_slot(1, ph, wr);
      chk("inc40_phase", ph, seq_a[k]);
      chk("inc40_wrap", wr, (k == 3) ? 1 : 0);
    end

    // Increment written in the very cycle voice 2 is read.
    @(negedge clk);
    do_reset();
    write_inc(2, 32'h10);
    wait_slot(2, ph, wr);
    chk("incw_first", ph, 32'h10);
    wait_mod(2);
    inc_we = 1'b1; inc_addr = 3'd2; inc_data = 8'h30;
    @(negedge clk);
    inc_we = 1'b0;
    chk("incw_voice", 32'(out_voice), 2);
    chk("incw_old", 32'(out_phase), 32'h20);
    wait_slot(2, ph, wr);
    chk("incw_new", ph, 32'h50);

    // Clear coinciding with voice 0's update.
    @(negedge clk);
    do_reset();
    write_inc(0, 32'h70);
    wait_slot(0, ph, wr);
    chk("clr_pre", ph, 32'h70);
    write_inc(0, 32'h20);
    wait_mod(0);
    clr_we = 1'b1; clr_addr = 3'd0;
    @(negedge clk);
    clr_we = 1'b0;
    chk("clr_voice", 32'(out_voice), 0);
    chk("clr_phase", 32'(out_phase), 0);
    chk("clr_wrap", 32'(out_wrap), 0);
    wait_slot(0, ph, wr);
    chk("clr_next", ph, 32'h20);

    // Maximum increment steps backwards.
    @(negedge clk);
    do_reset();
    write_inc(3, 32'hFF);
    wait_slot(3, ph, wr);
    chk("ff_phase1", ph, 32'hFF);
    chk("ff_wrap1", wr, 0);
    wait_slot(3, ph, wr);
    chk("ff_phase2", ph, 32'hFE);
    chk("ff_wrap2", wr, 1);

    // Hard sync of voice 1 to voice 0 (free-running without the feature).
    @(negedge clk);
    do_reset();
    sync_mask = 5'b00011;
    write_inc(0, 32'h80);
    write_inc(1, 32'h30);
    for (int k = 0; k < 3; k++) begin
      wait_slot(1, ph, wr);
      chk("sync_phase", ph, seq_s[k]);
      chk("sync_wrap", wr, 0);
    end
    sync_mask = '0;

    // Reset in the middle of a sweep.
    @(negedge clk);
    do_reset();
    write_inc(0, 32'h11);
    write_inc(1, 32'h22);
    wait_mod(2);
    do_reset();
    for (int v = 0; v < NV; v++) begin
      wait_slot(v, ph, wr);
      chk("midrst_phase", ph, 0);
    end

    // Randomised traffic, including out-of-range addresses.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      inc_we   = ($urandom_range(3) == 0);
      inc_addr = VA_W'($urandom_range(7));
      case ($urandom_range(3))
        0:       inc_data = 8'h00;
        1:       inc_data = 8'hFF;
        default: inc_data = P_W'($urandom_range(255));
      endcase
      clr_we    = ($urandom_range(9) == 0);
      clr_addr  = VA_W'($urandom_range(7));
      sync_mask = NV'($urandom_range((1 << NV) - 1));
    end
    @(negedge clk);
    inc_we = 1'b0;
    clr_we = 1'b0;
    repeat (2 * TD) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pac_multi.md
Name: pac_multi

Overview:
- Parametrised successor to the single-voice phase accumulator.
- Holds NUM_VOICES independent phase accumulators of PHASE_W bits and time-multiplexes them through one adder.
- Generates its own sample-rate clock enable and emits one phase word per voice per sample tick to the downstream sine-approximation stage.
- Wraps modulo 2^PHASE_W instead of saturating, exposes wrap events, and supports per-voice phase clear.

Parameters:
- NUM_VOICES, 8, number of voices, range 1..64.
- PHASE_W, 24, accumulator and increment width in bits.
- OUT_W, 12, phase bits sent downstream; the top OUT_W bits of the accumulator; OUT_W <= PHASE_W.
- TICK_DIV, 1000, clk cycles per sample tick; must be >= NUM_VOICES+2, which is checked at elaboration.
- VA_W, 3, voice index width = clog2(NUM_VOICES), minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- inc_we  in  1  increment write strobe.
- inc_addr  in  VA_W  voice selected for the increment write.
- inc_data  in  PHASE_W  new frequency increment.
- clr_we  in  1  phase-clear strobe (note-on retrigger).
- clr_addr  in  VA_W  voice to clear.
- sync_mask  in  NUM_VOICES  per-voice hard-sync enable; used only with PAC_SYNC_EN.
- tick  out  1  one-cycle sample-rate enable.
- out_valid  out  1  phase word valid.
- out_voice  out  VA_W  voice index of the phase word.
- out_phase  out  OUT_W  phase word.
- out_wrap  out  1  accumulator carried out on this update.
- busy  out  1  sweep in progress.

Behaviour:
- Reset (async assert, sync release):
  - All phases 0, all increments 0, divider 0.
  - tick, out_valid, out_wrap and busy are 0; out_voice and out_phase are 0.
- Divider:
  - Counts 0..TICK_DIV-1; tick is high for exactly one cycle when the count equals TICK_DIV-1, then the count returns to 0.
  - First tick occurs TICK_DIV cycles after reset release.
- Sequencer FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on tick, with v=0.
  - In SWEEP, one voice per clk: phase[v] <= (phase[v] + inc[v]) mod 2^PHASE_W; v increments.
  - SWEEP -> IDLE after voice NUM_VOICES-1.
  - busy is high exactly while in SWEEP.
- Output:
  - Registered. Voice v's result appears with out_valid=1 at cycle tick+2+v.
  - out_phase = new phase[PHASE_W-1 -: OUT_W]; out_wrap = carry out of the add.
  - out_valid is high for NUM_VOICES consecutive cycles per tick.
- Increment writes:
  - Accepted in any cycle and take effect at the next update of that voice.
  - A write in the same cycle that voice is being read for update: old increment is used this sweep, new one next sweep.
- Phase clear:
  - Forces phase[clr_addr] to 0.
  - If it coincides with that voice's update, the clear wins: stored phase is 0, out_phase is 0 and out_wrap is 0 for that slot.
- inc_we and clr_we in the same cycle are independent.
- Out-of-range addresses (>= NUM_VOICES) are ignored.
- Increment 0 holds the phase. Increment 2^PHASE_W-1 steps backwards by 1 each tick, with out_wrap=1 except when the old phase is 0.
- A tick arriving while busy cannot occur, because of the TICK_DIV constraint.
- rst_n asserted mid-sweep aborts the sweep immediately and returns everything to reset values.

Optional Feature:
- Macro: PAC_SYNC_EN.
- With the macro defined:
  - Voice v>0 with sync_mask[v]=1 is loaded with 0 instead of phase+inc when voice v-1 wrapped earlier in the same sweep; out_wrap for that slot is 0.
  - A clear on the same voice and cycle gives the same result.
  - sync_mask[0] is ignored.
- Without the macro: sync_mask is unused and every voice accumulates freely.

Decomposition:
- Shared constants include: CLK_FREQ, PAC_FREQ (TICK_DIV defaults to CLK_FREQ/PAC_FREQ), SINE_WORDS-derived OUT_W, and a pac2sine bus typedef sized {VA_W, OUT_W, wrap, valid}.
- Natural sub-module: pac_tick_gen, the parametrised divider producing tick, reused by other rate-based blocks.
- Phase and increment storage are plain register arrays inside pac_multi; no RAM macro.

Test Plan:
- Reset, TICK_DIV=10, NUM_VOICES=4: first tick at cycle 10; out_valid high for cycles 12..15, voices 0..3, all phases 0.
- PHASE_W=8, OUT_W=8, inc[1]=0x40: voice 1 outputs 0x40, 0x80, 0xC0, then 0x00 with out_wrap=1 on the fourth tick.
- inc_we for voice 2 written during voice 2's update cycle: old increment applied this sweep, new one next sweep.
- clr_we on voice 0 coinciding with its update (phase 0x70, inc 0x20): out_phase=0, out_wrap=0; next tick 0x20.
- PAC_SYNC_EN defined, sync_mask=0b0010, inc[0]=0x80, inc[1]=0x30: voice 1 reads 0x30, then 0x00 on voice 0's wrap tick, then 0x30.
- rst_n pulsed low mid-sweep after voice 1: outputs drop to 0 immediately; all phases restart from 0.
